// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - decode and ID/EX/MEM/WB control pipeline with load-use, redirect and divide sequencing
module ctrl_pipeline #(
  parameter bit ENABLE_M    = 1'b1,
  parameter int DIV_LATENCY = 32,
  parameter int RA_W        = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_id,
  input  logic            valid_id,
  input  logic            redirect_ex,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            ex_valid,
  output logic [1:0]      ex_aluop,
  output logic            ex_alusrc,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_jalr,
  output logic            ex_lui,
  output logic            ex_auipc,
  output logic            ex_mdu,
  output logic [2:0]      ex_funct3,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_illegal,
  output logic            mem_memread,
  output logic            mem_memwrite,
  output logic            mem_regwrite,
  output logic            mem_memtoreg,
  output logic [RA_W-1:0] mem_rd,
  output logic            wb_regwrite,
  output logic            wb_memtoreg,
  output logic [RA_W-1:0] wb_rd
);

  localparam int CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LATENCY - 1);

  typedef struct packed {
    logic            valid;
    logic [1:0]      aluop;
    logic            alusrc;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            lui;
    logic            auipc;
    logic            mdu;
    logic [2:0]      funct3;
    logic [RA_W-1:0] rd;
    logic            illegal;
    logic            memread;
    logic            memwrite;
    logic            regwrite;
    logic            memtoreg;
  } idex_t;

  typedef struct packed {
    logic            memread;
    logic            memwrite;
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] rd;
  } memwb_t;

  idex_t   idex, idex_nx, dec;
  exmem_t  exmem, exmem_nx;
  memwb_t  memwb;
  logic [CW-1:0] cnt, cnt_nx;
  logic use_rs1, use_rs2, load_use, busy;
  logic [6:0] opcode, funct7;
  logic [RA_W-1:0] rs1, rs2;

  assign opcode = instr_id[6:0];
  assign funct7 = instr_id[31:25];
  assign rs1    = RA_W'(instr_id[19:15]);
  assign rs2    = RA_W'(instr_id[24:20]);

  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      7'd51: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec.aluop = 2'b10; dec.regwrite = 1'b1;
          use_rs1 = 1'b1; use_rs2 = 1'b1;
        end else if (ENABLE_M && funct7 == 7'b0000001) begin
          dec.aluop = 2'b10; dec.mdu = 1'b1; dec.regwrite = 1'b1;
          use_rs1 = 1'b1; use_rs2 = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'd19:  begin dec.aluop = 2'b11; dec.alusrc = 1'b1; dec.regwrite = 1'b1; use_rs1 = 1'b1; end
      7'd3:   begin
        dec.alusrc = 1'b1; dec.memread = 1'b1; dec.memtoreg = 1'b1; dec.regwrite = 1'b1;
        use_rs1 = 1'b1;
      end
      7'd35:  begin dec.alusrc = 1'b1; dec.memwrite = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'd99:  begin dec.aluop = 2'b01; dec.branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'd111: begin dec.jump = 1'b1; dec.regwrite = 1'b1; end
      7'd103: begin
        dec.jump = 1'b1; dec.jalr = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b11;
        dec.regwrite = 1'b1; use_rs1 = 1'b1;
      end
      7'd55:  begin dec.lui = 1'b1; dec.regwrite = 1'b1; end
      7'd23:  begin dec.auipc = 1'b1; dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
    dec.valid  = 1'b1;
    dec.funct3 = instr_id[14:12];
    dec.rd     = dec.regwrite ? RA_W'(instr_id[11:7]) : '0;
    if (!valid_id) begin
      dec     = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
  end

  assign busy     = (cnt != '0);
  assign load_use = idex.memread && (idex.rd != '0) &&
                    ((use_rs1 && rs1 == idex.rd) || (use_rs2 && rs2 == idex.rd));

  // Priority: an in-flight divide freezes everything, then redirect, then load-use.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_nx    = dec;
    exmem_nx   = '{memread: idex.memread, memwrite: idex.memwrite, regwrite: idex.regwrite,
                   memtoreg: idex.memtoreg, rd: idex.rd};
    cnt_nx     = cnt;
    if (busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_nx  = idex;
      exmem_nx = '0;
      cnt_nx   = cnt - CW'(1);
    end else if (redirect_ex) begin
      ifid_flush = 1'b1;
      idex_nx    = '0;
    end else if (load_use) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_nx = '0;
    end else if (dec.mdu && dec.funct3[2]) begin
      cnt_nx = DIV_LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
      cnt   <= '0;
    end else begin
      idex  <= idex_nx;
      exmem <= exmem_nx;
      memwb <= '{regwrite: exmem.regwrite, memtoreg: exmem.memtoreg, rd: exmem.rd};
      cnt   <= cnt_nx;
    end
  end

  assign ex_valid     = idex.valid;
  assign ex_aluop     = idex.aluop;
  assign ex_alusrc    = idex.alusrc;
  assign ex_branch    = idex.branch;
  assign ex_jump      = idex.jump;
  assign ex_jalr      = idex.jalr;
  assign ex_lui       = idex.lui;
  assign ex_auipc     = idex.auipc;
  assign ex_mdu       = idex.mdu;
  assign ex_funct3    = idex.funct3;
  assign ex_rd        = idex.rd;
  assign ex_illegal   = idex.illegal;
  assign mem_memread  = exmem.memread;
  assign mem_memwrite = exmem.memwrite;
  assign mem_regwrite = exmem.regwrite;
  assign mem_memtoreg = exmem.memtoreg;
  assign mem_rd       = exmem.rd;
  assign wb_regwrite  = memwb.regwrite;
  assign wb_memtoreg  = memwb.memtoreg;
  assign wb_rd        = memwb.rd;

  // The divider cannot abandon an operation, so a redirect must not arrive mid-divide.
  a_no_redirect_when_busy: assert property (@(posedge clk) disable iff (rst) !(redirect_ex && busy));

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - directed bench for ctrl_pipeline (M enabled, DIV_LATENCY=4; M disabled, DIV_LATENCY=1)
module tb_ctrl_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_id = '0;
  logic        valid_id = 1'b0;
  logic        redirect_ex = 1'b0;

  logic       pc_en, ifid_en, ifid_flush, ex_valid, ex_alusrc, ex_branch, ex_jump, ex_jalr;
  logic       ex_lui, ex_auipc, ex_mdu, ex_illegal, mem_memread, mem_memwrite, mem_regwrite;
  logic       mem_memtoreg, wb_regwrite, wb_memtoreg;
  logic [1:0] ex_aluop;
  logic [2:0] ex_funct3;
  logic [4:0] ex_rd, mem_rd, wb_rd;

  logic       pc_en_b, ifid_en_b, ifid_flush_b, ex_valid_b, ex_alusrc_b, ex_branch_b, ex_jump_b;
  logic       ex_jalr_b, ex_lui_b, ex_auipc_b, ex_mdu_b, ex_illegal_b, mem_memread_b, mem_memwrite_b;
  logic       mem_regwrite_b, mem_memtoreg_b, wb_regwrite_b, wb_memtoreg_b;
  logic [1:0] ex_aluop_b;
  logic [2:0] ex_funct3_b;
  logic [4:0] ex_rd_b, mem_rd_b, wb_rd_b;

  int checks = 0;
  int errors = 0;
  int stalls;

  always #5 clk = ~clk;

  ctrl_pipeline #(.ENABLE_M(1'b1), .DIV_LATENCY(4), .RA_W(5)) u_dut (
    .clk(clk), .rst(rst), .instr_id(instr_id), .valid_id(valid_id), .redirect_ex(redirect_ex),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .ex_valid(ex_valid),
    .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_jalr(ex_jalr), .ex_lui(ex_lui), .ex_auipc(ex_auipc), .ex_mdu(ex_mdu),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_illegal(ex_illegal),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_regwrite(mem_regwrite),
    .mem_memtoreg(mem_memtoreg), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd)
  );

  ctrl_pipeline #(.ENABLE_M(1'b0), .DIV_LATENCY(1), .RA_W(5)) u_dut_b (
    .clk(clk), .rst(rst), .instr_id(instr_id), .valid_id(valid_id), .redirect_ex(redirect_ex),
    .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b), .ex_valid(ex_valid_b),
    .ex_aluop(ex_aluop_b), .ex_alusrc(ex_alusrc_b), .ex_branch(ex_branch_b), .ex_jump(ex_jump_b),
    .ex_jalr(ex_jalr_b), .ex_lui(ex_lui_b), .ex_auipc(ex_auipc_b), .ex_mdu(ex_mdu_b),
    .ex_funct3(ex_funct3_b), .ex_rd(ex_rd_b), .ex_illegal(ex_illegal_b),
    .mem_memread(mem_memread_b), .mem_memwrite(mem_memwrite_b), .mem_regwrite(mem_regwrite_b),
    .mem_memtoreg(mem_memtoreg_b), .mem_rd(mem_rd_b),
    .wb_regwrite(wb_regwrite_b), .wb_memtoreg(wb_memtoreg_b), .wb_rd(wb_rd_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    valid_id    = 1'b0;
    redirect_ex = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    // reset
    repeat (2) tick();
    check("rst_pc_en", pc_en, 1);
    check("rst_ifid_en", ifid_en, 1);
    check("rst_flush", ifid_flush, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_wb_regwrite", wb_regwrite, 0);
    rst = 1'b0;

    // addi x1,x0,10 through to WB
    instr_id = 32'h00A00093; valid_id = 1'b1;
    tick();
    valid_id = 1'b0;
    check("addi_ex_aluop", ex_aluop, 2'b11);
    check("addi_ex_alusrc", ex_alusrc, 1);
    check("addi_ex_rd", ex_rd, 1);
    check("addi_ex_valid", ex_valid, 1);
    tick();
    check("addi_mem_regwrite", mem_regwrite, 1);
    tick();
    check("addi_wb_regwrite", wb_regwrite, 1);
    check("addi_wb_rd", wb_rd, 1);
    check("addi_wb_memtoreg", wb_memtoreg, 0);
    drain();

    // lw x5,0(x2); add x6,x5,x7 -> one stall cycle
    instr_id = 32'h00012283; valid_id = 1'b1;
    tick();
    instr_id = 32'h00728333;
    #1;
    check("lu_pc_en", pc_en, 0);
    check("lu_ifid_en", ifid_en, 0);
    tick();
    check("lu_bubble", ex_valid, 0);
    check("lu_mem_memread", mem_memread, 1);
    check("lu_mem_rd", mem_rd, 5);
    check("lu_pc_en_after", pc_en, 1);
    tick();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_rd", ex_rd, 6);
    check("lu_add_aluop", ex_aluop, 2'b10);
    drain();

    // lw x0 then add using x0 -> no stall
    instr_id = 32'h00012003; valid_id = 1'b1;
    tick();
    check("lw0_ex_rd", ex_rd, 0);
    instr_id = 32'h00700333;
    #1;
    check("lw0_no_stall", pc_en, 1);
    tick();
    check("lw0_add_rd", ex_rd, 6);
    drain();

    // div x3,x4,x5: 3 stall cycles on DIV_LATENCY=4, illegal on the M-less instance
    instr_id = 32'h025241B3; valid_id = 1'b1;
    tick();
    valid_id = 1'b0;
    check("div_ex_mdu", ex_mdu, 1);
    check("div_ex_funct3", ex_funct3, 3'b100);
    check("divb_illegal", ex_illegal_b, 1);
    check("divb_mdu", ex_mdu_b, 0);
    check("divb_pc_en", pc_en_b, 1);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      if (pc_en === 1'b0) stalls++;
      check("div_hold_rd", ex_rd, 3);
      if (i > 0) check("div_mem_bubble", mem_regwrite, 0);
      tick();
    end
    check("div_stall_cycles", stalls, 3);
    check("div_mem_rd", mem_rd, 3);
    check("div_mem_regwrite", mem_regwrite, 1);
    check("div_ex_after", ex_valid, 0);
    tick();
    check("div_wb_regwrite", wb_regwrite, 1);
    check("div_wb_rd", wb_rd, 3);
    drain();

    // mul x3,x4,x5: never stalls
    instr_id = 32'h025201B3; valid_id = 1'b1;
    tick();
    valid_id = 1'b0;
    check("mul_ex_mdu", ex_mdu, 1);
    check("mul_pc_en", pc_en, 1);
    tick();
    check("mul_mem_rd", mem_rd, 3);
    drain();

    // beq in EX, lw in ID, redirect
    instr_id = 32'h00208063; valid_id = 1'b1;
    tick();
    check("beq_branch", ex_branch, 1);
    check("beq_aluop", ex_aluop, 2'b01);
    check("beq_rd", ex_rd, 0);
    instr_id = 32'h00012283; redirect_ex = 1'b1;
    #1;
    check("redir_flush", ifid_flush, 1);
    check("redir_pc_en", pc_en, 1);
    tick();
    redirect_ex = 1'b0; valid_id = 1'b0;
    check("redir_bubble", ex_valid, 0);
    drain();

    // redirect beats a pending load-use stall
    instr_id = 32'h00012283; valid_id = 1'b1;
    tick();
    instr_id = 32'h00728333; redirect_ex = 1'b1;
    #1;
    check("redir_lu_pc_en", pc_en, 1);
    check("redir_lu_ifid_en", ifid_en, 1);
    check("redir_lu_flush", ifid_flush, 1);
    tick();
    redirect_ex = 1'b0; valid_id = 1'b0;
    check("redir_lu_bubble", ex_valid, 0);
    check("redir_lu_mem_memread", mem_memread, 1);
    drain();

    // auipc x8,1 then illegal opcode 0x7F
    instr_id = 32'h00001417; valid_id = 1'b1;
    tick();
    check("auipc_auipc", ex_auipc, 1);
    check("auipc_lui", ex_lui, 0);
    check("auipc_alusrc", ex_alusrc, 1);
    check("auipc_rd", ex_rd, 8);
    instr_id = 32'h0000007F;
    tick();
    valid_id = 1'b0;
    check("ill_flag", ex_illegal, 1);
    check("ill_valid", ex_valid, 1);
    check("ill_ctrl", {ex_aluop, ex_alusrc, ex_branch, ex_jump, ex_jalr, ex_lui, ex_auipc, ex_mdu}, 0);
    check("ill_rd", ex_rd, 0);
    tick();
    check("ill_mem_ctrl", {mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg}, 0);
    drain();

    // reset during the 2nd busy cycle of a divide
    instr_id = 32'h025241B3; valid_id = 1'b1;
    tick();
    valid_id = 1'b0;
    tick();
    check("rstdiv_busy", pc_en, 0);
    #2;
    rst = 1'b1;
    #1;
    check("rstdiv_ex_valid", ex_valid, 0);
    check("rstdiv_ex_mdu", ex_mdu, 0);
    check("rstdiv_ex_rd", ex_rd, 0);
    check("rstdiv_pc_en", pc_en, 1);
    check("rstdiv_mem", mem_regwrite, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rstdiv_release_pc_en", pc_en, 1);
    check("rstdiv_release_ifid_en", ifid_en, 1);
    check("rstdiv_release_ex_valid", ex_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
